// File: rtl/clock_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_counter: 12-hour BCD timekeeper with 1 s prescaler, set-mode load  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clock_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  STATE,
  input  logic [18:0] timeset,
  output logic [18:0] time_out,
  output logic        tick,
  output logic        half_sec
);

  localparam logic [1:0]       c_MODE_SET  = 2'b01;
  localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_HALF      = CNT_W'(TICK_DIV / 2);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  logic [1:0]       r_state_d;
  logic [CNT_W-1:0] r_presc;
  logic             r_tick;
  logic [18:0]      r_time;

  logic [3:0]  w_s, w_m, w_h;
  logic [2:0]  w_s10, w_m10;
  logic        w_h10;
  logic        w_c_s, w_c_s10, w_c_m, w_c_m10;
  logic [18:0] w_next;
  logic        w_hold, w_load;

  assign w_hold = (STATE == c_MODE_SET);
  assign w_load = !w_hold && (r_state_d == c_MODE_SET);

  // BCD ripple; >= keeps out-of-range loaded digits from running away
  always_comb begin
    w_s     = r_time[3:0];
    w_s10   = r_time[6:4];
    w_m     = r_time[10:7];
    w_m10   = r_time[13:11];
    w_h     = r_time[17:14];
    w_h10   = r_time[18];
    w_c_s   = 1'b0;
    w_c_s10 = 1'b0;
    w_c_m   = 1'b0;
    w_c_m10 = 1'b0;

    if (r_time[3:0] >= 4'd9) begin
      w_s   = 4'd0;
      w_c_s = 1'b1;
    end else begin
      w_s = r_time[3:0] + 4'd1;
    end

    if (w_c_s) begin
      if (r_time[6:4] >= 3'd5) begin
        w_s10   = 3'd0;
        w_c_s10 = 1'b1;
      end else begin
        w_s10 = r_time[6:4] + 3'd1;
      end
    end

    if (w_c_s10) begin
      if (r_time[10:7] >= 4'd9) begin
        w_m   = 4'd0;
        w_c_m = 1'b1;
      end else begin
        w_m = r_time[10:7] + 4'd1;
      end
    end

    if (w_c_m) begin
      if (r_time[13:11] >= 3'd5) begin
        w_m10   = 3'd0;
        w_c_m10 = 1'b1;
      end else begin
        w_m10 = r_time[13:11] + 3'd1;
      end
    end

    // 11 (or any invalid 12..19) wraps to 00; x9 rolls into the tens digit
    if (w_c_m10) begin
      if (r_time[18] && (r_time[17:14] >= 4'd1)) begin
        w_h   = 4'd0;
        w_h10 = 1'b0;
      end else if (r_time[17:14] >= 4'd9) begin
        w_h   = 4'd0;
        w_h10 = 1'b1;
      end else begin
        w_h = r_time[17:14] + 4'd1;
      end
    end

    w_next = {w_h10, w_h, w_m10, w_m, w_s10, w_s};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_d <= 2'b00;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_time    <= '0;
    end else begin
      r_state_d <= STATE;
      r_tick    <= 1'b0;
      if (w_hold) begin
        r_presc <= '0;
      end else if (w_load) begin
        r_presc <= '0;
        r_time  <= timeset;
      end else if (r_presc == c_TICK_LAST) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
        r_time  <= w_next;
      end else begin
        r_presc <= r_presc + c_ONE;
      end
    end
  end

  assign time_out = r_time;
  assign tick     = r_tick;
  assign half_sec = (r_presc < c_HALF);

endmodule
`default_nettype wire
